// File: rtl/autobaud_detector.sv
// -----------------------------------------------------------------------------
// autobaud_detector
//
// Measures the width of the single low pulse produced by a 0x80 sync character
// (start bit plus seven zero data bits) on a UART line. It converts that width
// into the oversampling divisor used by a 16x baud tick generator:
//   divisor = round(low_cycles / (16 * LOW_BITS))
// The divisor output keeps its last good value, so the generator stays stable
// between calibrations and after a failed attempt.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   rx         in   asynchronous serial line, idles high
//   start      in   single-cycle arm request, honoured only while idle
//   baud_dvsr  out  12-bit divisor for the baud generator
//   dvsr_valid out  high once any measurement has succeeded
//   busy       out  high whenever a measurement is armed or in progress
//   done       out  one-cycle pulse, new divisor loaded
//   err        out  one-cycle pulse, measurement rejected
// -----------------------------------------------------------------------------
module autobaud_detector #(
    parameter int LOW_BITS     = 8,
    parameter int SHIFT        = 7,
    parameter int CNT_W        = 20,
    parameter int MIN_DVSR     = 4,
    parameter int DEFAULT_DVSR = 326,
    parameter int IDLE_CYC     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    input  logic        start,
    output logic [11:0] baud_dvsr,
    output logic        dvsr_valid,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // The quotient is formed wide enough to hold the full rounded count and
    // never narrower than the 12-bit output, so the range check sees every bit.
    localparam int QW   = (CNT_W + 1 > 12) ? CNT_W + 1 : 12;
    localparam int IW   = (IDLE_CYC > 1) ? $clog2(IDLE_CYC + 1) : 1;
    // Half of one divisor step: 2^(SHIFT-1) == 8*LOW_BITS when SHIFT is
    // consistent with LOW_BITS.
    localparam int HALF = 8 * LOW_BITS;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_IDLE = 3'd1,
        WAIT_FALL = 3'd2,
        MEASURE   = 3'd3,
        CALC      = 3'd4,
        REPORT    = 3'd5
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             rx_m;
    logic             rx_s;
    logic [IW-1:0]    idle_cnt;
    logic [IW-1:0]    idle_cnt_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [QW-1:0]    q_calc;
    logic             done_next;
    logic             err_next;
    logic             dvsr_load;

    // Round-half-up division of the low-pulse width by 2^SHIFT.
    function automatic logic [QW-1:0] round_div(input logic [CNT_W-1:0] c);
        logic [QW-1:0] s;
        s = QW'(c) + QW'(HALF);
        return s >> SHIFT;
    endfunction

    // Accept only divisors the generator can use and that fit the output.
    function automatic logic dvsr_in_range(input logic [QW-1:0] q);
        return (q >= QW'(MIN_DVSR)) && (q <= QW'(4095));
    endfunction

    assign q_calc = round_div(cnt);
    assign busy   = (state != IDLE);

    // Two-flop synchronizer. It resets to the idle level so that no false
    // falling edge appears when reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_comb begin
        state_next    = state;
        idle_cnt_next = idle_cnt;
        cnt_next      = cnt;
        done_next     = 1'b0;
        err_next      = 1'b0;
        dvsr_load     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next    = WAIT_IDLE;
                    idle_cnt_next = '0;
                    cnt_next      = '0;
                end
            end
            WAIT_IDLE: begin
                // Require a run of idle-high cycles so that arming in the
                // middle of a frame cannot mistake a data bit for the sync.
                if (!rx_s) begin
                    idle_cnt_next = '0;
                end else if (idle_cnt == IW'(IDLE_CYC - 1)) begin
                    idle_cnt_next = '0;
                    state_next    = WAIT_FALL;
                end else begin
                    idle_cnt_next = idle_cnt + IW'(1);
                end
            end
            WAIT_FALL: begin
                if (!rx_s) begin
                    cnt_next   = CNT_W'(1);
                    state_next = MEASURE;
                end
            end
            MEASURE: begin
                // Saturation is tested before incrementing so the count never
                // wraps into a plausible-looking small value.
                if (rx_s) begin
                    state_next = CALC;
                end else if (&cnt) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            CALC: begin
                // Result flags and the new divisor are registered together so
                // that done and the updated baud_dvsr appear in the REPORT cycle.
                state_next = REPORT;
                if (dvsr_in_range(q_calc)) begin
                    done_next = 1'b1;
                    dvsr_load = 1'b1;
                end else begin
                    err_next = 1'b1;
                end
            end
            REPORT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idle_cnt   <= '0;
            cnt        <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            baud_dvsr  <= 12'(DEFAULT_DVSR);
            dvsr_valid <= 1'b0;
        end else begin
            state    <= state_next;
            idle_cnt <= idle_cnt_next;
            cnt      <= cnt_next;
            done     <= done_next;
            err      <= err_next;
            if (dvsr_load) begin
                baud_dvsr  <= q_calc[11:0];
                dvsr_valid <= 1'b1;
            end
        end
    end

endmodule
